// File: rtl/serial_pkg.sv
// Shared definitions for the byte-oriented serial link (transmit and receive sides).
package serial_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with registered occupancy/full flags and a combinational head read.
module byte_fifo
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = BYTE_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        din_i,
    output logic [DATA_WIDTH-1:0]        dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push is refused while full even if a pop frees a slot on the same edge.
    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && (count_q != '0);
        head_d  = do_pop  ? next_ptr(head_q) : head_q;
        tail_d  = do_push ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[tail_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/byte_serializer.sv
// Queues parallel bytes and emits each MSB first as a DATA_WIDTH-cycle write_out frame,
// separating back-to-back frames by GAP_CYCLES idle cycles.
module byte_serializer
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = BYTE_W,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                  clock_1MHz,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enqueue_in,
    input  logic                  ready_in,
    output logic                  data_out,
    output logic                  write_out,
    output logic [7:0]            len_out,
    output logic                  status_out
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   write_q, write_d;
    logic                   data_q, data_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_dout;
    logic [CNT_W-1:0]       fifo_count;
    logic                   can_start;
    logic                   load;

    byte_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i   (clock_1MHz),
        .rst_i   (reset),
        .push_i  (enqueue_in),
        .pop_i   (fifo_pop),
        .din_i   (data_in),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        can_start = !fifo_empty && ready_in;

        case (state_q)
            IDLE: begin
                if (can_start) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (can_start) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d   = SEND;
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
        end
        fifo_pop = load;

        // Outputs are derived from next state so they are registered yet aligned with it.
        write_d = (state_d == SEND);
        data_d  = write_d && shift_d[DATA_WIDTH-1];
    end

    always_ff @(posedge clock_1MHz) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            write_q   <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            write_q   <= write_d;
            data_q    <= data_d;
        end
    end

    assign write_out  = write_q;
    assign data_out   = data_q;
    assign len_out    = 8'(fifo_count);
    assign status_out = fifo_full;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: queue/frame-timeline reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_byte_serializer;

    localparam int DEPTH = 8;
    localparam int GAPC  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enq = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] din = 8'h00;
    logic       data_out;
    logic       write_out;
    logic [7:0] len_out;
    logic       status_out;

    int checks = 0;
    int errors = 0;

    byte_serializer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (8),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clock_1MHz (clk),
        .reset      (reset),
        .data_in    (din),
        .enqueue_in (enq),
        .ready_in   (rdy),
        .data_out   (data_out),
        .write_out  (write_out),
        .len_out    (len_out),
        .status_out (status_out)
    );

    always #500 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus a frame timeline.
    // phase 0 = idle, 1..8 = showing bit (8-phase), 9..8+GAPC = gap cycles.
    logic [7:0] mq[$];
    logic [7:0] done_q[$];
    logic [7:0] cur = 8'h00;
    int         phase = 0;
    bit         mvalid = 1'b0;
    bit         full_pre;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            phase  = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            full_pre = (mq.size() == DEPTH);
            if (phase == 8) done_q.push_back(cur);
            if (phase == 0 || phase == 8 + GAPC) begin
                if (mq.size() > 0 && rdy) begin
                    cur   = mq.pop_front();
                    phase = 1;
                end else begin
                    phase = 0;
                end
            end else begin
                phase++;
            end
            if (enq && !full_pre) mq.push_back(din);
        end
    end

    always @(negedge clk) begin
        int exp_w;
        int exp_d;
        if (mvalid) begin
            exp_w = (phase >= 1 && phase <= 8) ? 1 : 0;
            exp_d = 0;
            if (exp_w == 1) exp_d = int'(cur[8 - phase]);
            check("model write_out", int'(write_out), exp_w);
            check("model data_out", int'(data_out), exp_d);
            check("model len_out", int'(len_out), mq.size());
            check("model status_out", int'(status_out), (mq.size() == DEPTH) ? 1 : 0);
        end
    end

    // Loopback receiver: reassembles each complete 8-cycle frame.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    int         rx_n = 0;

    always @(negedge clk) begin
        if (write_out) begin
            rx_sh = {rx_sh[6:0], data_out};
            rx_n++;
            if (rx_n == 8) begin
                rx_q.push_back(rx_sh);
                rx_n = 0;
            end
        end else begin
            rx_n = 0;
        end
    end

    task automatic drive(input bit e, input logic [7:0] d, input bit r, input bit rs = 1'b0);
        enq   = e;
        din   = d;
        rdy   = r;
        reset = rs;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, r);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rx_q.delete();
        done_q.delete();
    endtask

    task automatic wait_rise(input string name, input int maxc, input bit r);
        int n = 0;
        while (!write_out && n < maxc) begin
            drive(1'b0, 8'h00, r);
            n++;
        end
        check(name, int'(write_out), 1);
    endtask

    task automatic cmp_rx_model(input string name);
        check({name, " frame count"}, rx_q.size(), done_q.size());
        for (int i = 0; i < rx_q.size() && i < done_q.size(); i++)
            check({name, " frame byte"}, int'(rx_q[i]), int'(done_q[i]));
    endtask

    initial begin
        logic [7:0] bits;
        int highs;
        int lowrun;
        int gap_meas;

        @(negedge clk);

        // 1: reset state, single byte latency and bit order
        do_reset();
        check("reset write_out", int'(write_out), 0);
        check("reset data_out", int'(data_out), 0);
        check("reset len_out", int'(len_out), 0);
        check("reset status_out", int'(status_out), 0);
        drive(1'b1, 8'hAA, 1'b1);
        check("t1 len after push", int'(len_out), 1);
        check("t1 write before frame", int'(write_out), 0);
        bits = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            check("t1 write in frame", int'(write_out), 1);
            bits = {bits[6:0], data_out};
            if (i == 0) check("t1 len after pop", int'(len_out), 0);
        end
        check("t1 byte", int'(bits), 8'hAA);
        drive(1'b0, 8'h00, 1'b1);
        check("t1 write after frame", int'(write_out), 0);
        idle(3, 1'b1);
        cmp_rx_model("t1");

        // 2: back-to-back frames separated by exactly one low cycle
        do_reset();
        drive(1'b1, 8'h2D, 1'b1);
        drive(1'b1, 8'h5F, 1'b1);
        highs = write_out ? 1 : 0;
        lowrun = 0;
        gap_meas = -1;
        for (int i = 0; i < 25; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (write_out) begin
                if (lowrun > 0 && gap_meas < 0) gap_meas = lowrun;
                highs++;
                lowrun = 0;
            end else begin
                lowrun++;
            end
        end
        check("t2 high cycles", highs, 16);
        check("t2 gap cycles", gap_meas, 1);
        check("t2 rx count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("t2 rx byte0", int'(rx_q[0]), 45);
            check("t2 rx byte1", int'(rx_q[1]), 95);
        end
        cmp_rx_model("t2");

        // 3: fill while not ready, overflow dropped, then drain in order
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            if (i == 8) begin
                check("t3 len full", int'(len_out), 8);
                check("t3 status full", int'(status_out), 1);
            end
            if (i == 9) check("t3 len after drop", int'(len_out), 8);
        end
        drive(1'b0, 8'h00, 1'b1);
        check("t3 status after pop", int'(status_out), 0);
        check("t3 len after pop", int'(len_out), 7);
        idle(90, 1'b1);
        check("t3 rx count", rx_q.size(), 8);
        for (int i = 0; i < rx_q.size() && i < 8; i++) check("t3 rx byte", int'(rx_q[i]), i + 1);
        cmp_rx_model("t3");

        // 4: simultaneous push+pop keeps occupancy; push during SEND
        do_reset();
        drive(1'b1, 8'hB1, 1'b0);
        drive(1'b1, 8'hB2, 1'b0);
        drive(1'b1, 8'hB3, 1'b0);
        check("t4 len three", int'(len_out), 3);
        drive(1'b1, 8'hB4, 1'b1);
        check("t4 len push+pop", int'(len_out), 3);
        idle(3, 1'b1);
        drive(1'b1, 8'hB5, 1'b1);
        check("t4 len push in SEND", int'(len_out), 4);
        idle(60, 1'b1);
        check("t4 rx count", rx_q.size(), 5);
        for (int i = 0; i < rx_q.size() && i < 5; i++) check("t4 rx byte", int'(rx_q[i]), 8'hB1 + i);
        cmp_rx_model("t4");

        // 5: reset mid-frame aborts and flushes the queue
        do_reset();
        drive(1'b1, 8'hF0, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        idle(3, 1'b1);
        check("t5 write at bit4", int'(write_out), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check("t5 write after reset", int'(write_out), 0);
        check("t5 data after reset", int'(data_out), 0);
        check("t5 len after reset", int'(len_out), 0);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (write_out) highs++;
        end
        check("t5 no frames", highs, 0);
        check("t5 rx count", rx_q.size(), 0);

        // 6: ready dropped mid-frame; frame completes, next byte waits
        do_reset();
        drive(1'b1, 8'h3C, 1'b1);
        drive(1'b1, 8'h77, 1'b1);
        idle(3, 1'b1);
        idle(15, 1'b0);
        check("t6 write held off", int'(write_out), 0);
        check("t6 len waiting", int'(len_out), 1);
        check("t6 rx count first", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("t6 rx byte0", int'(rx_q[0]), 8'h3C);
        wait_rise("t6 resume", 5, 1'b1);
        idle(15, 1'b1);
        check("t6 rx count", rx_q.size(), 2);
        if (rx_q.size() == 2) check("t6 rx byte1", int'(rx_q[1]), 8'h77);
        cmp_rx_model("t6");

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 499) == 0));
            if (reset) begin
                rx_q.delete();
                done_q.delete();
            end
        end
        idle(100, 1'b1);
        check("rand queue drained", int'(len_out), 0);
        cmp_rx_model("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Transmit-side counterpart of the deserializer: accepts parallel bytes into an internal queue and shifts them out serially, MSB first.
- Each byte is framed by write_out held high for exactly 8 consecutive cycles. A deserializer on the other end (data_in/write_in) reassembles the bytes unchanged.
- Sits between a byte-producing block and the serial link, in the 1 MHz clock domain.

Parameters:
DEPTH, 8, number of byte entries in the internal queue (2..255).
DATA_WIDTH, 8, bits per word; also the frame length in cycles.
GAP_CYCLES, 1, idle cycles (write_out low) between consecutive frames (>=1).

Ports:
clock_1MHz  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  8  byte to enqueue.
enqueue_in  input  1  one-cycle strobe; pushes data_in when queue not full.
ready_in  input  1  far end can accept a frame; checked only when a frame starts.
data_out  output  1  serial bit, MSB first, valid while write_out=1.
write_out  output  1  frame strobe, high for exactly DATA_WIDTH cycles per byte.
len_out  output  8  current queue occupancy (0..DEPTH).
status_out  output  1  queue full (len_out==DEPTH).

Behaviour:
- Interface: one clock, clock_1MHz; reset is synchronous and active-high.
- All outputs are registered.
- Reset, sampled on an edge:
  - state=IDLE, queue emptied, bit counter=0, gap counter=0.
  - data_out=0, write_out=0, len_out=0, status_out=0.
  - Reset overrides every other input. A frame in progress is aborted: write_out is low after the reset edge and no partial-frame resume occurs.
- Queue:
  - Circular FIFO with head/tail pointers wrapping at DEPTH.
  - Push on enqueue_in && !full. enqueue_in while full is silently dropped: len_out and contents unchanged.
  - Pop occurs only when a frame is loaded.
  - Push and pop on the same edge: len_out unchanged, both pointers advance.
  - Push to an empty queue: len_out=1 after that edge.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if len_out>0 && ready_in, then on the edge: load head byte into the shift register, pop, go to SEND, bit counter=0. Otherwise stay.
  - SEND: write_out=1, data_out=shift[7]. Each edge shifts left by 1 and increments the bit counter. On the edge where the counter==7, go to GAP with gap counter=0 and write_out=0.
  - GAP: write_out=0, data_out=0. On the edge ending the final gap cycle (counter==GAP_CYCLES-1):
    - if len_out>0 && ready_in, load the next byte and go straight to SEND;
    - else go to IDLE.
    - Consecutive frames are therefore separated by exactly GAP_CYCLES low cycles.
- Latency: enqueue at edge E0 into an empty queue with ready_in=1:
  - len_out=1 after E0;
  - write_out=1 with data_out=bit7 after E1, and len_out=0 after E1;
  - last bit (bit0) after E8;
  - write_out=0 after E9.
- ready_in:
  - deasserting it mid-frame has no effect; the frame completes;
  - while it is low, IDLE holds and the queue keeps accepting bytes.
- data_out is forced to 0 whenever write_out=0.
- Width rules:
  - len_out is zero-extended to 8 bits;
  - the bit counter is 3 bits;
  - the gap counter is sized $clog2(GAP_CYCLES+1).

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - localparam BYTE_W=8.
  - The deserializer reuses BYTE_W.
- One sub-module, byte_fifo:
  - parameterised DEPTH/DATA_WIDTH;
  - signals push, pop, din, dout (head, combinational read), count, full, empty.
- The top contains the FSM, shift register and counters.

Test Plan:
1. Reset, enqueue 0xAA, ready_in=1 -> after 1 cycle write_out=1 for 8 cycles, data_out=1,0,1,0,1,0,1,0; len_out goes 1 then 0; write_out low after.
2. Enqueue 0x2D and 0x5F on consecutive cycles -> bits 0,0,1,0,1,1,0,1, then exactly 1 low cycle, then 0,1,0,1,1,1,1,1; looped back through the deserializer, the bytes read out are 45 then 95.
3. ready_in=0, enqueue 9 bytes 0x01..0x09 -> len_out=8, status_out=1 after 8th push, 9th dropped; raise ready_in -> frames 0x01..0x08 in order, status_out=0 after first pop.
4. Enqueue while a frame is in SEND and while the queue has 3 entries -> len_out unchanged on a simultaneous push+pop edge; every byte transmitted in order.
5. reset=1 at bit 4 of 0xF0 with 2 queued bytes -> next cycle write_out=0, data_out=0, len_out=0; no further frames without new enqueues.
6. Drop ready_in during bit 3 of 0x3C -> full frame 0,0,1,1,1,1,0,0 completes; the next queued byte waits in IDLE until ready_in=1.
